// File: rtl/idct_block_scheduler_pkg.sv
// Shared types for the IDCT block scheduler: coefficient block payload,
// channel tag width and scheduler FSM states.
package idct_block_scheduler_pkg;

    localparam int unsigned CH_DEFAULT = 3;
    localparam int unsigned COEF_W     = 12;
    localparam int unsigned BLK_N      = 8;
    localparam int unsigned BLK_W      = BLK_N * BLK_N * COEF_W;
    localparam int unsigned CH_TAG_W   = $clog2(CH_DEFAULT + 1);

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [BLK_N-1:0][BLK_N-1:0] idct_blk_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } sched_state_t;

    // Channel tag width for an arbitrary requester count.
    function automatic int unsigned tag_width(input int unsigned ch);
        return $clog2(ch + 1);
    endfunction

endpackage

// File: rtl/idct_block_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant and
// wraps modulo CH; returns a one-hot grant and the winning index.
module idct_rr_arbiter
    import idct_block_scheduler_pkg::*;
#(
    parameter int unsigned CH = CH_DEFAULT
) (
    input  logic [CH-1:0]               req,
    input  logic [tag_width(CH)-1:0]    last_grant,
    output logic [CH-1:0]               grant,
    output logic [tag_width(CH)-1:0]    idx
);

    localparam int unsigned TAG_W = tag_width(CH);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= CH; k++) begin
            cand = (32'(last_grant) + k) % CH;
            for (int unsigned i = 0; i < CH; i++) begin
                if (!found && (i == cand) && req[i]) begin
                    grant[i] = 1'b1;
                    idx      = TAG_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/idct_block_scheduler.sv
// Schedules coefficient blocks from CH requesters into a shared 2D IDCT with
// round-robin fairness, a minimum issue spacing and an in-flight credit limit.
module idct_block_scheduler
    import idct_block_scheduler_pkg::*;
#(
    parameter int unsigned CH           = CH_DEFAULT,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned ISSUE_GAP    = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CH-1:0]                     req_valid,
    input  idct_blk_t [CH-1:0]                req_block,
    output logic [CH-1:0]                     req_ready,
    output logic                              idct_valid,
    output logic [$clog2(CH+1)-1:0]           idct_channel,
    output idct_blk_t                         idct_block,
    input  logic                              done_valid,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              busy,
    output logic                              err_underflow
);

    localparam int unsigned TAG_W = $clog2(CH + 1);
    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned GAP_W = 4;

    sched_state_t     state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [TAG_W-1:0] last_grant_q, last_grant_d;
    logic             idct_valid_q, idct_valid_d;
    logic [TAG_W-1:0] idct_channel_q, idct_channel_d;
    idct_blk_t        idct_block_q, idct_block_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [CH-1:0]    arb_grant;
    logic [TAG_W-1:0] arb_idx;
    logic             can_issue;
    logic             xfer;
    logic             underflow;
    logic             retire;

    idct_rr_arbiter #(
        .CH (CH)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .idx        (arb_idx)
    );

    // Grant is combinational so a requester can transfer in the same cycle.
    assign can_issue = (state_q == ST_IDLE) && (inflight_q < INF_W'(MAX_INFLIGHT)) && !rst;
    assign req_ready = can_issue ? arb_grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign underflow = done_valid && (inflight_q == '0);
    assign retire    = done_valid && !underflow;

    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        inflight_d     = inflight_q;
        last_grant_d   = last_grant_q;
        idct_valid_d   = 1'b0;
        idct_channel_d = idct_channel_q;
        idct_block_d   = idct_block_q;
        err_d          = err_q | underflow;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_W'(ISSUE_GAP - 1);
                end
            end
            ST_GAP: begin
                // Leaving when the count would reach zero keeps pulses ISSUE_GAP apart.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase

        if (xfer) begin
            idct_valid_d   = 1'b1;
            idct_channel_d = arb_idx;
            last_grant_d   = arb_idx;
            for (int i = 0; i < CH; i++) begin
                if (req_ready[i]) begin
                    idct_block_d = req_block[i];
                end
            end
        end

        case ({xfer, retire})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        busy_d = (state_d != ST_IDLE) || (inflight_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            gap_cnt_q      <= '0;
            inflight_q     <= '0;
            last_grant_q   <= TAG_W'(CH - 1);
            idct_valid_q   <= 1'b0;
            idct_channel_q <= '0;
            idct_block_q   <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            inflight_q     <= inflight_d;
            last_grant_q   <= last_grant_d;
            idct_valid_q   <= idct_valid_d;
            idct_channel_q <= idct_channel_d;
            idct_block_q   <= idct_block_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    assign idct_valid    = idct_valid_q;
    assign idct_channel  = idct_channel_q;
    assign idct_block    = idct_block_q;
    assign inflight      = inflight_q;
    assign busy          = busy_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Randomized bench for idct_block_scheduler with a cycle-level reference model
// and directed scenarios for single issue, fairness, credits, underflow and reset.
module tb_idct_block_scheduler;
    import idct_block_scheduler_pkg::*;

    localparam int unsigned CH    = 3;
    localparam int unsigned MAXI  = 4;
    localparam int unsigned GAP   = 9;
    localparam int unsigned TAG_W = $clog2(CH + 1);
    localparam int unsigned INF_W = $clog2(MAXI + 1);
    localparam int          SPACING = (GAP >= 2) ? int'(GAP) : 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CH-1:0]       req_valid = '0;
    idct_blk_t [CH-1:0]  req_block = '0;
    logic [CH-1:0]       req_ready;
    logic                idct_valid;
    logic [TAG_W-1:0]    idct_channel;
    idct_blk_t           idct_block;
    logic                done_valid = 1'b0;
    logic [INF_W-1:0]    inflight;
    logic                busy;
    logic                err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    idct_block_scheduler #(
        .CH           (CH),
        .MAX_INFLIGHT (MAXI),
        .ISSUE_GAP    (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_block     (req_block),
        .req_ready     (req_ready),
        .idct_valid    (idct_valid),
        .idct_channel  (idct_channel),
        .idct_block    (idct_block),
        .done_valid    (done_valid),
        .inflight      (inflight),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: issue spacing by cycle arithmetic, credits as a count.
    int        m_cyc, m_last, m_infl, m_lastg, m_ch;
    bit        m_issued, m_err, m_valid;
    idct_blk_t m_blk;

    always @(negedge clk) begin : cmp
        logic [CH-1:0] rdy;
        int g;
        int c;
        bit gap_act;
        if (rst) begin
            m_cyc = 0; m_last = 0; m_issued = 0; m_infl = 0; m_lastg = CH - 1;
            m_err = 0; m_valid = 0; m_ch = 0; m_blk = '0;
            chk("rst_req_ready", BLK_W'(req_ready), '0);
            chk("rst_idct_valid", BLK_W'(idct_valid), '0);
            chk("rst_idct_channel", BLK_W'(idct_channel), '0);
            chk("rst_idct_block", BLK_W'(idct_block), '0);
            chk("rst_inflight", BLK_W'(inflight), '0);
            chk("rst_busy", BLK_W'(busy), '0);
            chk("rst_err", BLK_W'(err_underflow), '0);
        end else begin
            gap_act = m_issued && ((m_cyc - m_last) < SPACING);
            rdy = '0;
            g = -1;
            if (!gap_act && (m_infl < int'(MAXI))) begin
                for (int k = 1; k <= int'(CH); k++) begin
                    c = (m_lastg + k) % int'(CH);
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) rdy[g] = 1'b1;
            chk("req_ready", BLK_W'(req_ready), BLK_W'(rdy));
            chk("idct_valid", BLK_W'(idct_valid), BLK_W'(m_valid));
            chk("idct_channel", BLK_W'(idct_channel), BLK_W'(m_ch));
            chk("idct_block", BLK_W'(idct_block), BLK_W'(m_blk));
            chk("inflight", BLK_W'(inflight), BLK_W'(m_infl));
            chk("busy", BLK_W'(busy), BLK_W'(gap_act || (m_infl != 0)));
            chk("err_underflow", BLK_W'(err_underflow), BLK_W'(m_err));
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_ch = g; m_blk = req_block[g]; m_lastg = g; m_last = m_cyc; m_issued = 1;
            end
            if (done_valid && m_infl == 0) m_err = 1;
            m_infl = m_infl + ((g >= 0) ? 1 : 0) - ((done_valid && m_infl > 0) ? 1 : 0);
            m_cyc++;
        end
    end

    logic [CH-1:0] xfer_mask;

    // One clock: done applied for the cycle, transferred requests retired.
    task automatic step(input logic d);
        done_valid = d;
        @(negedge clk);
        #2;
        xfer_mask = req_valid & req_ready;
        @(posedge clk);
        #2;
        done_valid = 1'b0;
        req_valid  = req_valid & ~xfer_mask;
    endtask

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                req_block[i][r][c] = 12'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        done_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int chs[$];
        int cyc_at[$];
        int cyc;
        int waited;
        bit ok;

        // Reset must block grants even with every requester pending.
        rst = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_ready", BLK_W'(req_ready), '0);
        do_reset();

        // Single block on channel 0.
        new_req(0);
        req_block[0][0][0] = 12'd100;
        #1;
        chk("lit_single_ready", BLK_W'(req_ready), BLK_W'(3'b001));
        step(1'b0);
        chk("lit_single_valid", BLK_W'(idct_valid), BLK_W'(1'b1));
        chk("lit_single_chan", BLK_W'(idct_channel), '0);
        chk("lit_single_coef", BLK_W'(idct_block[0][0]), BLK_W'(12'd100));
        chk("lit_single_inflight", BLK_W'(inflight), BLK_W'(1));
        step(1'b0);
        chk("lit_single_pulse_once", BLK_W'(idct_valid), '0);
        repeat (10) step(1'b0);

        // Fairness and spacing with all requesters held, then credit stall.
        do_reset();
        for (int i = 0; i < int'(CH); i++) new_req(i);
        cyc = 0;
        for (int t = 0; t < 60 && chs.size() < 4; t++) begin
            step(1'b0);
            cyc++;
            if (idct_valid) begin
                chs.push_back(int'(idct_channel));
                cyc_at.push_back(cyc);
            end
            for (int i = 0; i < int'(CH); i++) if (!req_valid[i]) new_req(i);
        end
        chk("lit_fair_count", BLK_W'(chs.size()), BLK_W'(4));
        if (chs.size() == 4) begin
            chk("lit_fair_ch0", BLK_W'(chs[0]), BLK_W'(0));
            chk("lit_fair_ch1", BLK_W'(chs[1]), BLK_W'(1));
            chk("lit_fair_ch2", BLK_W'(chs[2]), BLK_W'(2));
            chk("lit_fair_ch3", BLK_W'(chs[3]), BLK_W'(0));
            for (int i = 1; i < 4; i++)
                chk("lit_fair_spacing", BLK_W'(cyc_at[i] - cyc_at[i-1]), BLK_W'(9));
        end
        waited = 0;
        for (int t = 0; t < 20; t++) begin
            step(1'b0);
            if (idct_valid) waited++;
        end
        chk("lit_stall_no_issue", BLK_W'(waited), '0);
        chk("lit_stall_inflight", BLK_W'(inflight), BLK_W'(4));
        #1;
        chk("lit_stall_ready", BLK_W'(req_ready), '0);
        step(1'b1);
        ok = 0;
        waited = 0;
        for (int t = 0; t < 30 && !ok; t++) begin
            step(1'b0);
            waited++;
            if (idct_valid) ok = 1;
        end
        chk("lit_stall_resume", BLK_W'(ok), BLK_W'(1'b1));
        chk("lit_stall_resume_within_gap", BLK_W'(waited <= int'(GAP)), BLK_W'(1'b1));

        // Transfer and completion in the same cycle at inflight 2.
        do_reset();
        new_req(0);
        new_req(1);
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            step(1'b0);
            if (inflight == INF_W'(2)) ok = 1;
        end
        chk("lit_simul_setup", BLK_W'(ok), BLK_W'(1'b1));
        new_req(2);
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            #1;
            if ((req_valid & req_ready) != '0) begin
                ok = 1;
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        chk("lit_simul_seen", BLK_W'(ok), BLK_W'(1'b1));
        chk("lit_simul_inflight", BLK_W'(inflight), BLK_W'(2));
        chk("lit_simul_chan", BLK_W'(idct_channel), BLK_W'(2));
        repeat (10) step(1'b0);

        // Underflow is sticky until reset.
        do_reset();
        step(1'b1);
        chk("lit_uf_err", BLK_W'(err_underflow), BLK_W'(1'b1));
        chk("lit_uf_inflight", BLK_W'(inflight), '0);
        repeat (3) step(1'b0);
        chk("lit_uf_sticky", BLK_W'(err_underflow), BLK_W'(1'b1));
        do_reset();
        chk("lit_uf_cleared", BLK_W'(err_underflow), '0);

        // Asynchronous reset while in GAP with three blocks outstanding.
        for (int i = 0; i < int'(CH); i++) new_req(i);
        ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            step(1'b0);
            if (inflight == INF_W'(3)) ok = 1;
        end
        chk("lit_async_setup", BLK_W'(ok), BLK_W'(1'b1));
        chk("lit_async_busy_before", BLK_W'(busy), BLK_W'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        chk("lit_async_valid", BLK_W'(idct_valid), '0);
        chk("lit_async_inflight", BLK_W'(inflight), '0);
        chk("lit_async_busy", BLK_W'(busy), '0);
        chk("lit_async_ready", BLK_W'(req_ready), '0);
        chk("lit_async_chan", BLK_W'(idct_channel), '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < int'(CH); i++) new_req(i);
        step(1'b0);
        chk("lit_async_first_valid", BLK_W'(idct_valid), BLK_W'(1'b1));
        chk("lit_async_first_chan", BLK_W'(idct_channel), '0);

        // Random traffic with occasional resets and underflows.
        do_reset();
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < int'(CH); i++)
                if (!req_valid[i] && ($urandom % 3 == 0)) new_req(i);
            if ($urandom % 500 == 0) do_reset();
            step((inflight != '0) ? ($urandom % 6 == 0) : ($urandom % 60 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
